// File: rtl/i2c_rx_frame_buffer_pkg.sv
// Shared types and defaults for the I2C receive frame buffer.
package i2c_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_e;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_DW    = 8;

  // Width needed for a byte counter that reaches DEPTH without wrapping.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2c_rx_frame_buffer_mem.sv
// Frame storage: one write port, one registered read port, storage not reset.
// A read and a write to the same entry in one cycle return the old contents.
module i2c_rx_mem #(
  parameter int DEPTH = 32,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write the captured byte and register the read word (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/i2c_rx_frame_buffer.sv
// Captures one I2C read burst into a fixed-depth frame buffer with byte
// count, running XOR checksum, completion/error status and a host read port.
//
// state   | meaning
// IDLE    | waiting for start, strobes ignored
// CAPTURE | storing bytes, busy high
// DONE    | DEPTH bytes stored, extra strobes set overflow
// ERROR   | frame aborted by the master, counts frozen
module i2c_rx_frame_buffer
  import i2c_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = DEFAULT_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] rx_byte,
  input  logic          rx_valid,
  input  logic          rx_abort,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overflow,
  output logic [AW:0]   byte_count,
  output logic [DW-1:0] checksum
);

  localparam int            CW       = count_width(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_e           state;
  logic [DEPTH-1:0] valid_q;
  logic             rd_hit_q;
  logic [DW-1:0]    mem_rd_data;
  logic             wr_en;

  // start wins over a same-cycle byte, so the byte never reaches storage.
  assign wr_en = (state == CAPTURE) && rx_valid && !start;

  i2c_rx_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (byte_count[AW-1:0]),
    .wr_data (rx_byte),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // Frame sequencing, counters, checksum and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
      valid_q    <= '0;
    end else if (start) begin
      state      <= CAPTURE;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
      valid_q    <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (rx_valid) begin
            valid_q[byte_count[AW-1:0]] <= 1'b1;
            byte_count <= byte_count + (AW+1)'(1);
            checksum   <= checksum ^ rx_byte;
          end
          if (rx_abort) begin
            state     <= ERROR;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (rx_valid && (byte_count == LAST_IDX)) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          if (rx_valid) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read side: sample the valid bit with the request so the result is masked to
  // zero for entries not yet written (pre-write view on same-cycle collisions).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_hit_q <= rd_en && valid_q[rd_addr];
    end
  end

  assign rd_data = rd_hit_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_i2c_rx_frame_buffer.sv
// Self-checking bench for i2c_rx_frame_buffer: status checks inline per test,
// read data checked through an expected-value queue drained by a monitor.
module tb_i2c_rx_frame_buffer;

  localparam int DEPTH = 32;
  localparam int DW    = 8;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] rx_byte;
  logic          rx_valid;
  logic          rx_abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic          overflow;
  logic [AW:0]   byte_count;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  i2c_rx_frame_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_abort   (rx_abort),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  // Read-result scoreboard: every rd_valid must match the oldest queued value.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h with no read pending", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data got %h exp %h", rd_data, e);
        end
      end
    end
  end

  // One cycle of stimulus, applied at a falling edge; queues expected read data.
  task automatic drive(input logic s, input logic v, input logic [DW-1:0] b,
                       input logic a, input logic r, input logic [AW-1:0] ad,
                       input logic [DW-1:0] exp_rd);
    start = s; rx_valid = v; rx_byte = b; rx_abort = a; rd_en = r; rd_addr = ad;
    if (r) exp_q.push_back(exp_rd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0, '0, 8'h00);
  endtask

  task automatic read(input logic [AW-1:0] ad, input logic [DW-1:0] exp_rd);
    drive(0, 0, 8'h00, 0, 1, ad, exp_rd);
  endtask

  task automatic send(input logic [DW-1:0] b);
    drive(0, 1, b, 0, 0, '0, 8'h00);
  endtask

  task automatic drain(input string name);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_rd_missing got %0d pending exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, frame_done, frame_err, overflow, rd_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {busy, frame_done, frame_err, overflow, rd_valid});
    end
    checks++;
    if (byte_count !== '0 || checksum !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_values got cnt %0d sum %h rd %h exp 0 0 0", byte_count, checksum, rd_data);
    end
    read(0, 8'h00);
    drain("reset");
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] sum = '0;
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    checks++;
    if (busy !== 1'b1 || byte_count !== '0) begin
      errors++;
      $display("FAIL start_busy got busy %b cnt %0d exp 1 0", busy, byte_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      send(DW'(i));
      sum ^= DW'(i);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done %b busy %b exp 1 0", frame_done, busy);
    end
    checks++;
    if (byte_count !== 6'd32 || checksum !== sum) begin
      errors++;
      $display("FAIL full_count got cnt %0d sum %h exp 32 %h", byte_count, checksum, sum);
    end
    read(5, 8'h05);
    idle(1);
    drain("full");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) read(AW'(i + 10), DW'(i + 10));
    read(31, 8'h1F);
    drain("b2b");
  endtask

  task automatic test_overflow();
    send(8'h77);
    checks++;
    if (overflow !== 1'b1 || byte_count !== 6'd32 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got ovf %b cnt %0d done %b exp 1 32 1", overflow, byte_count, frame_done);
    end
    read(31, 8'h1F);
    drain("ovf");
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    checks++;
    if (overflow !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_clear got ovf %b done %b busy %b exp 0 0 1", overflow, frame_done, busy);
    end
    read(31, 8'h00);
    drain("ovf_clr");
  endtask

  task automatic test_abort();
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    drive(0, 0, 8'h00, 1, 0, '0, 8'h00);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_err got err %b busy %b done %b exp 1 0 0", frame_err, busy, frame_done);
    end
    checks++;
    if (byte_count !== 6'd3 || checksum !== 8'h66) begin
      errors++;
      $display("FAIL abort_count got cnt %0d sum %h exp 3 66", byte_count, checksum);
    end
    send(8'h55);
    checks++;
    if (byte_count !== 6'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL error_ignore got cnt %0d ovf %b exp 3 0", byte_count, overflow);
    end
    read(3, 8'h00);
    read(1, 8'h3C);
    drain("abort");
  endtask

  task automatic test_start_priority();
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    send(8'h21);
    send(8'h42);
    drive(1, 1, 8'h11, 0, 0, '0, 8'h00);
    checks++;
    if (byte_count !== '0 || checksum !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_prio got cnt %0d sum %h busy %b exp 0 00 1", byte_count, checksum, busy);
    end
    read(0, 8'h00);
    drain("prio");
  endtask

  task automatic test_same_addr_rw();
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    for (int i = 1; i <= 4; i++) send(DW'(i));
    drive(0, 1, 8'h9C, 0, 1, 5'd4, 8'h00);
    read(4, 8'h9C);
    drain("collide");
    checks++;
    if (byte_count !== 6'd5 || checksum !== (8'h04 ^ 8'h9C)) begin
      errors++;
      $display("FAIL collide_count got cnt %0d sum %h exp 5 %h", byte_count, checksum, 8'h04 ^ 8'h9C);
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 8'h00, 0, 0, '0, 8'h00);
    for (int i = 0; i < 10; i++) send(DW'(8'hC0 + i));
    checks++;
    if (byte_count !== 6'd10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got cnt %0d busy %b exp 10 1", byte_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, frame_err, overflow, rd_valid} !== 5'b0 ||
        byte_count !== '0 || checksum !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL mid_reset got flags %b cnt %0d sum %h rd %h exp 0", {busy, frame_done, frame_err, overflow, rd_valid}, byte_count, checksum, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read(0, 8'h00);
    read(9, 8'h00);
    drain("mid_reset");
    send(8'h12);
    checks++;
    if (byte_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got cnt %0d busy %b exp 0 0", byte_count, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 0; rx_valid = 0; rx_byte = '0; rx_abort = 0; rd_en = 0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_start_priority();
    test_same_addr_rw();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/i2c_rx_frame_buffer.md
# i2c_rx_frame_buffer

Captures the byte stream delivered by the I2C master engine during a read transaction into a fixed-depth frame buffer. Tracks byte count, running XOR checksum and frame completion/error status, and offers a registered random-access read port to the host logic. Sits directly downstream of the I2C master read path, consuming one byte per strobe. Fixed frame length matches the master's 32-byte read burst.

## Interface
- DEPTH, 32, frame length in bytes; power of two, 2..256
- DW, 8, data width per entry
- AW, $clog2(DEPTH), read address width (derived)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a new capture and clears status
- rx_byte  in  DW  received byte from I2C master
- rx_valid  in  1  one-cycle strobe, rx_byte valid this cycle
- rx_abort  in  1  one-cycle pulse; master lost arbitration/NACK, abort frame
- rd_en  in  1  host read request
- rd_addr  in  AW  host read address
- rd_data  out  DW  read data, registered
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- busy  out  1  high in CAPTURE
- frame_done  out  1  level; DEPTH bytes captured
- frame_err  out  1  level; frame aborted
- overflow  out  1  sticky; rx_valid seen in DONE
- byte_count  out  AW+1  bytes captured in current frame
- checksum  out  DW  XOR of all bytes captured in current frame

## Operation
- States: IDLE, CAPTURE, DONE, ERROR.
- IDLE -> CAPTURE on start. Any state -> CAPTURE on start (restart). Clears byte_count, checksum, overflow, frame_done, frame_err and the per-entry valid vector.
- CAPTURE + rx_valid: mem[byte_count] <= rx_byte; valid[byte_count] <= 1; byte_count += 1; checksum ^= rx_byte.
- CAPTURE, write of entry DEPTH-1 -> DONE. frame_done = 1 until next start or reset.
- CAPTURE + rx_abort -> ERROR. frame_err = 1. byte_count and checksum hold their values at abort.
- rx_valid and rx_abort in the same cycle in CAPTURE: the byte is written, then the block goes to ERROR.
- start has priority over rx_valid/rx_abort in the same cycle: restart, the byte is discarded.
- rx_valid in IDLE or ERROR: ignored. rx_valid in DONE: ignored, overflow set (sticky).
- rx_abort outside CAPTURE: ignored.
- Reads are legal in every state.
  - rd_data = mem[rd_addr] if valid[rd_addr], else 0.
  - A read and a write to the same address in the same cycle return the pre-write view (0 if the entry was not yet valid).
- byte_count width AW+1 holds DEPTH exactly; no wrap. Writes are impossible once count = DEPTH because the block is in DONE.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, frame_done=0, frame_err=0, overflow=0, byte_count=0, checksum=0, state IDLE, valid vector 0. mem contents are not reset.
- rx_valid at cycle t: byte_count, checksum and valid bit updated at t+1. Readable with rd_en at t+1, data at t+2.
- Last byte at t: frame_done and busy=0 at t+1.
- start at t: busy=1 and all status cleared at t+1.
- rd_en at t: rd_valid=1 and rd_data at t+1. Back-to-back reads give one result per cycle.
- Reset asserted mid-frame: immediate return to IDLE, all outputs at reset values. Buffer reads 0 afterwards because the valid bits are cleared.

## Structure
- Package i2c_rx_pkg: state enum (IDLE/CAPTURE/DONE/ERROR), default DEPTH/DW constants, count-width helper.
- Sub-module i2c_rx_mem: DEPTH x DW, 1 write / 1 registered read, no reset on storage. Valid vector and zero-masking stay in the top.

## Test plan
- Reset, start, 32 strobes of bytes 0x00..0x1F -> frame_done=1, byte_count=32, checksum=0x00; reading addr 5 gives 0x05 one cycle later.
- start, 3 bytes 0xA5/0x3C/0xFF, then rx_abort -> frame_err=1, byte_count=3, checksum=0x66; addr 3 reads 0x00.
- Full frame, then an extra rx_valid 0x77 -> overflow=1, byte_count stays 32, addr 31 unchanged; next start clears overflow.
- start and rx_valid(0x11) in the same cycle during CAPTURE -> byte_count=0, checksum=0, addr 0 reads 0x00.
- rd_en addr 4 in the same cycle as the write of 0x9C to entry 4 -> rd_data=0x00; a repeat read next cycle gives 0x9C.
- rst_n asserted after 10 bytes -> all outputs 0, state IDLE; reading addr 0 gives 0x00.
